// File: rtl/fcl_dxl_status_rx.sv
// Dynamixel status-packet receiver: parses FF FF ID LEN ERR P.. CHK after an arm
// pulse, validates checksum/ID/length and latches the reply fields.
module fcl_dxl_status_rx #(
  parameter int unsigned MAX_PARAMS      = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 50000,
  localparam int unsigned PCW            = $clog2(MAX_PARAMS + 1),
  localparam int unsigned TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                    clk_in,
  input  logic                    _reset_in,
  input  logic [7:0]              rx_data_in,
  input  logic                    rx_data_valid_in,
  input  logic                    expect_in,
  input  logic [7:0]              expected_id_in,
  output logic                    busy_out,
  output logic                    pkt_done_out,
  output logic [1:0]              error_code_out,
  output logic                    timeout_out,
  output logic [7:0]              status_id_out,
  output logic [7:0]              status_err_out,
  output logic [PCW-1:0]          param_count_out,
  output logic [8*MAX_PARAMS-1:0] param_data_out
);

  typedef enum logic [3:0] {
    IDLE, HDR1, HDR2, ID, LEN, ERR, PARAM, CHK, DONE
  } state_t;

  state_t                  state;
  logic [7:0]              exp_id;
  logic [7:0]              id_reg;
  logic [7:0]              err_reg;
  logic [7:0]              acc;
  logic [PCW-1:0]          pcnt;
  logic [PCW-1:0]          rem;
  logic [TW-1:0]           tmo;
  logic [8*MAX_PARAMS-1:0] param_buf;

  always_ff @(posedge clk_in or negedge _reset_in) begin
    if (!_reset_in) begin
      state           <= IDLE;
      busy_out        <= 1'b0;
      pkt_done_out    <= 1'b0;
      error_code_out  <= 2'd0;
      timeout_out     <= 1'b0;
      status_id_out   <= 8'd0;
      status_err_out  <= 8'd0;
      param_count_out <= '0;
      param_data_out  <= '0;
      exp_id          <= 8'd0;
      id_reg          <= 8'd0;
      err_reg         <= 8'd0;
      acc             <= 8'd0;
      pcnt            <= '0;
      rem             <= '0;
      tmo             <= '0;
      param_buf       <= '0;
    end else begin
      pkt_done_out <= 1'b0;
      timeout_out  <= 1'b0;
      if (expect_in) begin
        // Arm or re-arm: any partial packet is dropped, a concurrent byte too
        state     <= HDR1;
        busy_out  <= 1'b1;
        exp_id    <= expected_id_in;
        tmo       <= TW'(TIMEOUT_CYCLES);
        acc       <= 8'd0;
        pcnt      <= '0;
        rem       <= '0;
        id_reg    <= 8'd0;
        err_reg   <= 8'd0;
        param_buf <= '0;
      end else begin
        case (state)
          IDLE: ;
          DONE: begin
            state    <= IDLE;
            busy_out <= 1'b0;
          end
          default: begin
            if (rx_data_valid_in) begin
              tmo <= TW'(TIMEOUT_CYCLES);
              case (state)
                HDR1: if (rx_data_in == 8'hFF) state <= HDR2;
                HDR2: state <= (rx_data_in == 8'hFF) ? ID : HDR1;
                ID: begin
                  if (rx_data_in != 8'hFF) begin
                    id_reg <= rx_data_in;
                    acc    <= acc + rx_data_in;
                    state  <= LEN;
                  end
                end
                LEN: begin
                  if (rx_data_in < 8'd2 || 32'(rx_data_in) > MAX_PARAMS + 32'd2) begin
                    state           <= DONE;
                    pkt_done_out    <= 1'b1;
                    error_code_out  <= 2'd3;
                    status_id_out   <= id_reg;
                    status_err_out  <= err_reg;
                    param_count_out <= pcnt;
                    param_data_out  <= param_buf;
                  end else begin
                    acc   <= acc + rx_data_in;
                    rem   <= PCW'(rx_data_in - 8'd2);
                    state <= ERR;
                  end
                end
                ERR: begin
                  err_reg <= rx_data_in;
                  acc     <= acc + rx_data_in;
                  state   <= (rem == '0) ? CHK : PARAM;
                end
                PARAM: begin
                  param_buf[8*pcnt +: 8] <= rx_data_in;
                  pcnt <= pcnt + PCW'(1);
                  acc  <= acc + rx_data_in;
                  if (pcnt == rem - PCW'(1)) state <= CHK;
                end
                CHK: begin
                  state           <= DONE;
                  pkt_done_out    <= 1'b1;
                  error_code_out  <= (rx_data_in != ~acc) ? 2'd1 :
                                     (id_reg != exp_id)   ? 2'd2 : 2'd0;
                  status_id_out   <= id_reg;
                  status_err_out  <= err_reg;
                  param_count_out <= pcnt;
                  param_data_out  <= param_buf;
                end
                default: ;
              endcase
            end else if (tmo <= TW'(1)) begin
              state       <= IDLE;
              busy_out    <= 1'b0;
              timeout_out <= 1'b1;
            end else begin
              tmo <= tmo - TW'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fcl_dxl_status_rx.sv
// Randomized bench for fcl_dxl_status_rx: packets are built field by field and
// the expected completion is derived from the packet format rules.
module tb_fcl_dxl_status_rx;
  localparam int unsigned MAXP = 4;
  localparam int unsigned TMO  = 40;
  localparam int unsigned PCW  = $clog2(MAXP + 1);

  logic                clk_in = 1'b0;
  logic                _reset_in;
  logic [7:0]          rx_data_in;
  logic                rx_data_valid_in;
  logic                expect_in;
  logic [7:0]          expected_id_in;
  logic                busy_out;
  logic                pkt_done_out;
  logic [1:0]          error_code_out;
  logic                timeout_out;
  logic [7:0]          status_id_out;
  logic [7:0]          status_err_out;
  logic [PCW-1:0]      param_count_out;
  logic [8*MAXP-1:0]   param_data_out;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int tmo_cnt = 0;

  fcl_dxl_status_rx #(.MAX_PARAMS(MAXP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_in(clk_in), ._reset_in(_reset_in), .rx_data_in(rx_data_in),
    .rx_data_valid_in(rx_data_valid_in), .expect_in(expect_in),
    .expected_id_in(expected_id_in), .busy_out(busy_out),
    .pkt_done_out(pkt_done_out), .error_code_out(error_code_out),
    .timeout_out(timeout_out), .status_id_out(status_id_out),
    .status_err_out(status_err_out), .param_count_out(param_count_out),
    .param_data_out(param_data_out)
  );

  always #5 clk_in = ~clk_in;

  // Pulse counters; a pulse is counted at the posedge that ends it
  always @(posedge clk_in) begin
    if (pkt_done_out) done_cnt++;
    if (timeout_out) tmo_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      rx_data_in = 8'($urandom);
      @(negedge clk_in);
    end
    rx_data_in = b;
    rx_data_valid_in = 1'b1;
    @(negedge clk_in);
    rx_data_valid_in = 1'b0;
    rx_data_in = 8'($urandom);
  endtask

  task automatic arm(input logic [7:0] id);
    expected_id_in = id;
    expect_in = 1'b1;
    @(negedge clk_in);
    expect_in = 1'b0;
    expected_id_in = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic wait_timeout(output int k);
    k = 0;
    while (!timeout_out && k < 200) begin
      @(negedge clk_in);
      k++;
    end
  endtask

  task automatic run_pkt(input logic [7:0] exp_id, input logic [7:0] pid,
                         input logic [7:0] len, input logic [7:0] err,
                         input logic [31:0] pdata, input logic [7:0] xmask,
                         input int extra_ff, input int junk, input bit rearm_done);
    int d0, n;
    logic [7:0] sum;
    logic [31:0] exp_pd;
    logic [1:0] exp_code;
    d0 = done_cnt;
    send_byte(8'($urandom), 0);
    arm(exp_id);
    chk("busy_armed", 32'(busy_out), 32'd1);
    for (int i = 0; i < junk; i++) send_byte(8'($urandom_range(0, 254)), $urandom_range(0, 3));
    for (int i = 0; i < 2 + extra_ff; i++) send_byte(8'hFF, $urandom_range(0, 3));
    send_byte(pid, $urandom_range(0, 3));
    send_byte(len, $urandom_range(0, 3));
    if (len < 8'd2 || int'(len) > int'(MAXP) + 2) begin
      chk("lenerr_done", 32'(pkt_done_out), 32'd1);
      chk("lenerr_code", 32'(error_code_out), 32'd3);
      chk("lenerr_id", 32'(status_id_out), 32'(pid));
      send_byte(err, 0);
      send_byte(8'hFF, 1);
      send_byte(8'hFF, 0);
      idle(2);
      chk("lenerr_one_pulse", 32'(done_cnt - d0), 32'd1);
      chk("lenerr_idle", 32'(busy_out), 32'd0);
      return;
    end
    n = int'(len) - 2;
    sum = pid + len + err;
    exp_pd = '0;
    for (int k = 0; k < n; k++) begin
      sum = sum + pdata[8*k +: 8];
      exp_pd[8*k +: 8] = pdata[8*k +: 8];
    end
    exp_code = (xmask != 8'd0) ? 2'd1 : (pid != exp_id) ? 2'd2 : 2'd0;
    send_byte(err, $urandom_range(0, 3));
    for (int k = 0; k < n; k++) send_byte(pdata[8*k +: 8], $urandom_range(0, 3));
    send_byte((~sum) ^ xmask, $urandom_range(0, 3));
    chk("done", 32'(pkt_done_out), 32'd1);
    chk("code", 32'(error_code_out), 32'(exp_code));
    chk("id", 32'(status_id_out), 32'(pid));
    chk("err", 32'(status_err_out), 32'(err));
    chk("count", 32'(param_count_out), 32'(n));
    chk("data", 32'(param_data_out), exp_pd);
    if (rearm_done) begin
      arm(exp_id);
      chk("rearm_in_done_busy", 32'(busy_out), 32'd1);
    end
    idle(2);
    chk("one_pulse", 32'(done_cnt - d0), 32'd1);
    chk("busy_after", 32'(busy_out), rearm_done ? 32'd1 : 32'd0);
  endtask

  function automatic logic [7:0] rand_id();
    return 8'($urandom_range(0, 254));
  endfunction

  initial begin
    int k, d0, t0;
    logic [7:0] eid, pid, len;
    _reset_in = 1'b0;
    rx_data_in = 8'd0;
    rx_data_valid_in = 1'b0;
    expect_in = 1'b0;
    expected_id_in = 8'd0;
    idle(3);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_done", 32'(pkt_done_out), 32'd0);
    chk("rst_tmo", 32'(timeout_out), 32'd0);
    chk("rst_code", 32'(error_code_out), 32'd0);
    chk("rst_id", 32'(status_id_out), 32'd0);
    chk("rst_err", 32'(status_err_out), 32'd0);
    chk("rst_count", 32'(param_count_out), 32'd0);
    chk("rst_data", 32'(param_data_out), 32'd0);
    _reset_in = 1'b1;
    idle(2);

    // Directed packets from the reference examples
    run_pkt(8'h01, 8'h01, 8'h02, 8'h00, 32'h0, 8'h00, 0, 0, 1'b0);
    run_pkt(8'h01, 8'h01, 8'h04, 8'h00, 32'h0000_0320, 8'h00, 0, 0, 1'b0);
    run_pkt(8'h01, 8'h01, 8'h02, 8'h00, 32'h0, 8'h07, 0, 0, 1'b0);
    run_pkt(8'h02, 8'h01, 8'h02, 8'h00, 32'h0, 8'h00, 0, 0, 1'b0);
    run_pkt(8'h01, 8'h01, 8'h07, 8'h00, 32'h0, 8'h00, 0, 0, 1'b0);
    run_pkt(8'h01, 8'h01, 8'h02, 8'h00, 32'h0, 8'h00, 1, 0, 1'b0);
    run_pkt(8'h05, 8'h05, 8'h06, 8'h20, 32'hFF00_A55A, 8'h00, 0, 2, 1'b1);

    // Randomized packets
    for (int i = 0; i < 40; i++) begin
      eid = rand_id();
      pid = ($urandom_range(0, 1) == 0) ? eid : rand_id();
      if ($urandom_range(0, 4) == 0)
        len = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 1)) : 8'($urandom_range(7, 255));
      else
        len = 8'($urandom_range(2, 6));
      run_pkt(eid, pid, len, 8'($urandom), $urandom,
              ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
              $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 7) == 0);
    end

    // Silent timeout after arming
    idle(2);
    d0 = done_cnt;
    t0 = tmo_cnt;
    arm(8'h01);
    wait_timeout(k);
    chk("tmo_latency_in_window", 32'(k >= int'(TMO) - 1 && k <= int'(TMO) + 1), 32'd1);
    idle(3);
    chk("tmo_one_pulse", 32'(tmo_cnt - t0), 32'd1);
    chk("tmo_busy", 32'(busy_out), 32'd0);
    chk("tmo_no_done", 32'(done_cnt - d0), 32'd0);

    // Every strobed byte reloads the counter
    t0 = tmo_cnt;
    arm(8'h01);
    for (int i = 0; i < 3; i++) send_byte(8'h55, int'(TMO) - 10);
    chk("tmo_reload_none", 32'(tmo_cnt - t0), 32'd0);
    chk("tmo_reload_busy", 32'(busy_out), 32'd1);
    wait_timeout(k);
    chk("tmo_reload_latency", 32'(k >= int'(TMO) - 1 && k <= int'(TMO) + 1), 32'd1);
    idle(2);

    // Re-arm mid-packet discards the partial packet
    d0 = done_cnt;
    arm(8'h01);
    send_byte(8'hFF, 0); send_byte(8'hFF, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
    arm(8'h01);
    send_byte(8'hFF, 0); send_byte(8'hFF, 1); send_byte(8'h01, 0);
    send_byte(8'h02, 0); send_byte(8'h00, 2); send_byte(8'hFC, 0);
    chk("rearm_done", 32'(pkt_done_out), 32'd1);
    chk("rearm_code", 32'(error_code_out), 32'd0);
    idle(2);
    chk("rearm_one_pulse", 32'(done_cnt - d0), 32'd1);

    // Arm coinciding with a byte strobe drops that byte
    d0 = done_cnt;
    expected_id_in = 8'h01;
    expect_in = 1'b1;
    rx_data_in = 8'hFF;
    rx_data_valid_in = 1'b1;
    @(negedge clk_in);
    expect_in = 1'b0;
    rx_data_valid_in = 1'b0;
    send_byte(8'hFF, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
    send_byte(8'h00, 0); send_byte(8'hFC, 0);
    idle(1);
    chk("arm_byte_dropped", 32'(done_cnt - d0), 32'd0);
    chk("arm_byte_busy", 32'(busy_out), 32'd1);
    send_byte(8'hFF, 0); send_byte(8'hFF, 0); send_byte(8'h01, 0);
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'hFC, 0);
    chk("arm_byte_done", 32'(pkt_done_out), 32'd1);
    idle(2);

    // Asynchronous reset mid-packet
    d0 = done_cnt;
    arm(8'h01);
    send_byte(8'hFF, 0); send_byte(8'hFF, 0); send_byte(8'h01, 0);
    #3 _reset_in = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy_out), 32'd0);
    chk("async_rst_id", 32'(status_id_out), 32'd0);
    @(negedge clk_in);
    _reset_in = 1'b1;
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'hFC, 0);
    idle(2);
    chk("post_rst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("post_rst_idle", 32'(busy_out), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fcl_dxl_status_rx.md
FCL_DXL_STATUS_RX -- requirements
Module: fcl_dxl_status_rx

Interface
REQ-001 Parameter MAX_PARAMS, default 4: the maximum number of status-packet parameter bytes that can be captured.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: clk_in cycles allowed between arming and a byte, or between two bytes, before a timeout.
REQ-003 Port clk_in, input, width 1: system clock.
REQ-004 Port _reset_in, input, width 1: reset, asynchronous, active-low.
REQ-005 Port rx_data_in, input, width 8: received byte from the UART.
REQ-006 Port rx_data_valid_in, input, width 1: single-cycle strobe that qualifies rx_data_in.
REQ-007 Port expect_in, input, width 1: single-cycle arm pulse, issued after a command has been transmitted.
REQ-008 Port expected_id_in, input, width 8: servo ID expected in the reply; sampled on expect_in.
REQ-009 Port busy_out, output, width 1: high while the block is armed, i.e. in any state other than IDLE.
REQ-010 Port pkt_done_out, output, width 1: one-cycle pulse when a packet completes, valid or not.
REQ-011 Port error_code_out, output, width 2: 0 = OK, 1 = checksum error, 2 = ID mismatch, 3 = length error; qualified by pkt_done_out.
REQ-012 Port timeout_out, output, width 1: one-cycle pulse when the timeout expires.
REQ-013 Port status_id_out, output, width 8: ID field of the last completed packet.
REQ-014 Port status_err_out, output, width 8: servo ERROR byte of the last completed packet.
REQ-015 Port param_count_out, output, width clogb2(MAX_PARAMS+1): number of parameter bytes received.
REQ-016 Port param_data_out, output, width 8*MAX_PARAMS: parameter k (0-based) is carried on bits [8k+7:8k].

Function
REQ-017 Packet format: FF FF ID LEN ERR P0..P(N-1) CHK, where LEN = N+2 and CHK = ~(ID+LEN+ERR+sum of P) mod 256.
REQ-018 Bytes are consumed only on cycles where rx_data_valid_in=1; all other rx_data_in values are ignored.
REQ-019 The state machine states are IDLE, HDR1, HDR2, ID, LEN, ERR, PARAM, CHK and DONE.
REQ-020 IDLE: received bytes are ignored; expect_in -> HDR1, with expected_id latched, the timeout counter loaded and the 8-bit checksum accumulator cleared.
REQ-021 HDR1: byte FF -> HDR2; any other byte -> stay in HDR1.
REQ-022 HDR2: byte FF -> ID; any other byte -> HDR1.
REQ-023 ID: byte FF -> stay in ID (extra preamble); any other byte -> store the ID, add it to the checksum, go to LEN.
REQ-024 LEN: LEN<2 or LEN>MAX_PARAMS+2 -> DONE with code 3, without waiting for the remaining bytes; otherwise store LEN, add it to the checksum, set remaining = LEN-2, go to ERR.
REQ-025 ERR: store the byte and add it to the checksum; remaining=0 -> CHK, otherwise -> PARAM.
REQ-026 PARAM: write the byte to slot param_count, increment param_count, add the byte to the checksum; on the last parameter -> CHK.
REQ-027 CHK: compare the byte with ~accumulator, then go to DONE.
REQ-028 Error code priority in CHK: checksum mismatch gives 1; otherwise a received ID different from expected_id gives 2; otherwise 0.
REQ-029 DONE lasts exactly one cycle: pkt_done_out=1, error_code_out is valid, then -> IDLE.
REQ-030 pkt_done_out is asserted on the cycle immediately after the cycle in which the CHK byte (or the bad LEN byte) is strobed.
REQ-031 status_id_out, status_err_out, param_count_out and param_data_out are updated on entry to DONE and held until the next DONE.
REQ-032 Unused parameter slots read as 00.
REQ-033 All checksum arithmetic is 8-bit and wraps mod 256; carries are discarded.
REQ-034 Timeout counter: reloaded to TIMEOUT_CYCLES on arming and on every strobed byte while armed, and decremented once per cycle.
REQ-035 When the timeout counter reaches 0 in any armed state except DONE: timeout_out pulses for one cycle, the state returns to IDLE, and pkt_done_out is not asserted.
REQ-036 expect_in while armed re-arms the block: state -> HDR1, counter reloaded, checksum and param_count cleared, and the partial packet is discarded with no pulse.
REQ-037 expect_in in the same cycle as rx_data_valid_in: the re-arm takes priority and the byte is dropped.
REQ-038 expect_in during DONE: the DONE pulse still completes, and the next state is HDR1.

Reset
REQ-039 While _reset_in=0: state IDLE; busy_out, pkt_done_out and timeout_out are 0; error_code_out, status_id_out, status_err_out, param_count_out and param_data_out are all zeros; internal counters are cleared.
REQ-040 Reset is asynchronous; deassertion mid-packet discards that packet, and the block stays in IDLE until the next expect_in.

Verification
REQ-041 Arm with ID=01, then send FF FF 01 02 00 FC -> pkt_done_out pulse, code 0, status_id_out=01, param_count_out=0.
REQ-042 Arm with ID=01, then send FF FF 01 04 00 20 03 D7 -> code 0, param_data_out[15:0]=0320, param_count_out=2.
REQ-043 Arm with ID=01, then send FF FF 01 02 00 FB -> code 1; with ID=02 send FF FF 01 02 00 FC -> code 2.
REQ-044 Send LEN=07 with MAX_PARAMS=4 -> code 3 on the cycle after the LEN strobe; the later bytes are ignored (block is in IDLE).
REQ-045 Arm and send no bytes for TIMEOUT_CYCLES -> single timeout_out pulse, busy_out=0, no pkt_done_out.
REQ-046 Preamble FF FF FF 01 02 00 FC -> code 0; re-arm mid-packet, then send a full good packet -> exactly one pkt_done_out.
